// File: rtl/pipe_ctrl_regs_if.sv
// Bus between the decode/hazard logic and the pipe_ctrl_regs register bank.
// StallCnt/FlushCnt exist only when PIPE_PERF_CNT_EN is defined.
interface pipe_ctrl_regs_if #(
  parameter int CNT_W = 32
);
  // Fetch / decode side
  logic        StallF;
  logic        StallD;
  logic        FlushE;
  logic        PCSrcD;
  logic [31:0] PCBranchD;
  logic [31:0] InstrF;
  logic [31:0] InstrD;
  logic [31:0] PCF;
  logic [31:0] PCPlus4D;

  // Decode controls
  logic [4:0]  rdD;
  logic        RegWriteD;
  logic        MemtoRegD;
  logic        MemWriteD;
  logic        RegDstD;
  logic        ALUSrcD;
  logic [2:0]  ALUControlD;

  // Execute stage
  logic [4:0]  rsE;
  logic [4:0]  rtE;
  logic [4:0]  rdE;
  logic        RegWriteE;
  logic        MemtoRegE;
  logic        MemWriteE;
  logic        ALUSrcE;
  logic [2:0]  ALUControlE;
  logic [4:0]  WriteRegE;

  // Memory and writeback stages
  logic        RegWriteM;
  logic        MemtoRegM;
  logic        MemWriteM;
  logic [4:0]  WriteRegM;
  logic        RegWriteW;
  logic        MemtoRegW;
  logic [4:0]  WriteRegW;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] StallCnt;
  logic [CNT_W-1:0] FlushCnt;
`else
  // CNT_W stays a legal parameter so instances are identical in both builds.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

  modport master (
    output StallF, StallD, FlushE, PCSrcD, PCBranchD, InstrF,
    output rdD, RegWriteD, MemtoRegD, MemWriteD, RegDstD, ALUSrcD, ALUControlD,
    input  InstrD, PCF, PCPlus4D,
    input  rsE, rtE, rdE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, ALUControlE, WriteRegE,
    input  RegWriteM, MemtoRegM, MemWriteM, WriteRegM,
    input  RegWriteW, MemtoRegW, WriteRegW
`ifdef PIPE_PERF_CNT_EN
    , input StallCnt, FlushCnt
`endif
  );

  modport slave (
    input  StallF, StallD, FlushE, PCSrcD, PCBranchD, InstrF,
    input  rdD, RegWriteD, MemtoRegD, MemWriteD, RegDstD, ALUSrcD, ALUControlD,
    output InstrD, PCF, PCPlus4D,
    output rsE, rtE, rdE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, ALUControlE, WriteRegE,
    output RegWriteM, MemtoRegM, MemWriteM, WriteRegM,
    output RegWriteW, MemtoRegW, WriteRegW
`ifdef PIPE_PERF_CNT_EN
    , output StallCnt, FlushCnt
`endif
  );
endinterface

// File: rtl/pipe_ctrl_regs.sv
// PC and IF/ID, ID/EX, EX/MEM, MEM/WB control/address registers of the 5-stage MIPS core.
// Optional saturating stall/flush counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_ctrl_regs #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic           clk,
  input  logic           reset,
  pipe_ctrl_regs_if.slave bus
);

  typedef struct packed {
    logic       reg_write;
    logic       memto_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dst;
    logic [2:0] alu_control;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } ex_regs_t;

  typedef struct packed {
    logic       reg_write;
    logic       memto_reg;
    logic       mem_write;
    logic [4:0] write_reg;
  } mem_regs_t;

  typedef struct packed {
    logic       reg_write;
    logic       memto_reg;
    logic [4:0] write_reg;
  } wb_regs_t;

  logic [31:0] pc_f;
  logic [31:0] pc_plus4_f;
  logic [31:0] pc_next;
  logic [31:0] instr_d;
  logic [31:0] pc_plus4_d;
  logic        flush_d;
  ex_regs_t    ex_next;
  ex_regs_t    ex_q;
  logic [4:0]  write_reg_e;
  mem_regs_t   mem_q;
  wb_regs_t    wb_q;

  assign pc_plus4_f = pc_f + 32'd4;
  // A stalled decode stage keeps its instruction, so a taken branch cannot squash it.
  assign flush_d    = bus.PCSrcD & ~bus.StallD;

  always_comb begin
    // NOTE: default first so every path assigns pc_next and no latch is inferred.
    pc_next = pc_plus4_f;
    if (bus.PCSrcD) pc_next = bus.PCBranchD;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_f <= RESET_PC;
    end else if (!bus.StallF) begin
      pc_f <= pc_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_d    <= '0;
      pc_plus4_d <= '0;
    end else if (!bus.StallD) begin
      if (flush_d) begin
        instr_d    <= '0;
        pc_plus4_d <= '0;
      end else begin
        instr_d    <= bus.InstrF;
        pc_plus4_d <= pc_plus4_f;
      end
    end
  end

  always_comb begin
    ex_next = '0;
    if (!bus.FlushE) begin
      ex_next.reg_write   = bus.RegWriteD;
      ex_next.memto_reg   = bus.MemtoRegD;
      ex_next.mem_write   = bus.MemWriteD;
      ex_next.alu_src     = bus.ALUSrcD;
      ex_next.reg_dst     = bus.RegDstD;
      ex_next.alu_control = bus.ALUControlD;
      ex_next.rs          = instr_d[25:21];
      ex_next.rt          = instr_d[20:16];
      ex_next.rd          = bus.rdD;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_next;
    end
  end

  assign write_reg_e = ex_q.reg_dst ? ex_q.rd : ex_q.rt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      mem_q.reg_write <= ex_q.reg_write;
      mem_q.memto_reg <= ex_q.memto_reg;
      mem_q.mem_write <= ex_q.mem_write;
      mem_q.write_reg <= write_reg_e;
      wb_q.reg_write  <= mem_q.reg_write;
      wb_q.memto_reg  <= mem_q.memto_reg;
      wb_q.write_reg  <= mem_q.write_reg;
    end
  end

  assign bus.PCF         = pc_f;
  assign bus.InstrD      = instr_d;
  assign bus.PCPlus4D    = pc_plus4_d;
  assign bus.rsE         = ex_q.rs;
  assign bus.rtE         = ex_q.rt;
  assign bus.rdE         = ex_q.rd;
  assign bus.RegWriteE   = ex_q.reg_write;
  assign bus.MemtoRegE   = ex_q.memto_reg;
  assign bus.MemWriteE   = ex_q.mem_write;
  assign bus.ALUSrcE     = ex_q.alu_src;
  assign bus.ALUControlE = ex_q.alu_control;
  assign bus.WriteRegE   = write_reg_e;
  assign bus.RegWriteM   = mem_q.reg_write;
  assign bus.MemtoRegM   = mem_q.memto_reg;
  assign bus.MemWriteM   = mem_q.mem_write;
  assign bus.WriteRegM   = mem_q.write_reg;
  assign bus.RegWriteW   = wb_q.reg_write;
  assign bus.MemtoRegW   = wb_q.memto_reg;
  assign bus.WriteRegW   = wb_q.write_reg;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Both counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (bus.StallD && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if ((bus.FlushE || flush_d) && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign bus.StallCnt = stall_cnt;
  assign bus.FlushCnt = flush_cnt;
`else
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl_regs.sv
// Scoreboard bench for pipe_ctrl_regs: an instruction-record pipeline model predicts every
// cycle's outputs, a monitor compares them after each rising edge.
`timescale 1ns/1ps
module tb_pipe_ctrl_regs;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam int          CNT_W    = 4;
  localparam int          CNT_MAX  = (1 << CNT_W) - 1;
  localparam int          N_RAND   = 400;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_ctrl_regs_if #(.CNT_W(CNT_W)) bus ();
  pipe_ctrl_regs #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        stall_f;
    logic        stall_d;
    logic        flush_e;
    logic        pcsrc;
    logic [31:0] branch;
    logic [31:0] instr_f;
    logic [4:0]  rd;
    logic        rw;
    logic        m2r;
    logic        mw;
    logic        regdst;
    logic        alusrc;
    logic [2:0]  aluc;
  } stim_t;

  // One instruction as it travels E -> M -> W; a bubble is the all-zero record.
  typedef struct packed {
    logic [31:0] instr;
    logic [4:0]  rd;
    logic        rw;
    logic        m2r;
    logic        mw;
    logic        regdst;
    logic        alusrc;
    logic [2:0]  aluc;
  } op_t;

  typedef struct packed {
    logic [31:0] pcf;
    logic [31:0] instr_d;
    logic [31:0] pc_plus4_d;
    logic [4:0]  rs_e;
    logic [4:0]  rt_e;
    logic [4:0]  rd_e;
    logic        rw_e;
    logic        m2r_e;
    logic        mw_e;
    logic        alusrc_e;
    logic [2:0]  aluc_e;
    logic [4:0]  wr_e;
    logic        rw_m;
    logic        m2r_m;
    logic        mw_m;
    logic [4:0]  wr_m;
    logic        rw_w;
    logic        m2r_w;
    logic [4:0]  wr_w;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
  } exp_t;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_d_instr;
  logic [31:0] m_d_pc4;
  op_t         m_ops [3];   // [0]=E, [1]=M, [2]=W
  int          m_stall_cnt;
  int          m_flush_cnt;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  function automatic logic [4:0] dest(input op_t op);
    return op.regdst ? op.rd : op.instr[20:16];
  endfunction

  task automatic model_reset();
    m_pc        = RESET_PC;
    m_d_instr   = '0;
    m_d_pc4     = '0;
    for (int i = 0; i < 3; i++) m_ops[i] = '0;
    m_stall_cnt = 0;
    m_flush_cnt = 0;
  endtask

  task automatic model_edge(input stim_t s);
    logic [31:0] pc4;
    op_t         issue;
    pc4          = m_pc + 32'd4;
    issue.instr  = m_d_instr;
    issue.rd     = s.rd;
    issue.rw     = s.rw;
    issue.m2r    = s.m2r;
    issue.mw     = s.mw;
    issue.regdst = s.regdst;
    issue.alusrc = s.alusrc;
    issue.aluc   = s.aluc;
    if (s.flush_e) issue = '0;
    m_ops[2] = m_ops[1];
    m_ops[1] = m_ops[0];
    m_ops[0] = issue;
    if (!s.stall_d) begin
      if (s.pcsrc) begin
        m_d_instr = '0;
        m_d_pc4   = '0;
      end else begin
        m_d_instr = s.instr_f;
        m_d_pc4   = pc4;
      end
    end
    if (!s.stall_f) m_pc = s.pcsrc ? s.branch : pc4;
    if (s.stall_d && m_stall_cnt < CNT_MAX) m_stall_cnt++;
    if ((s.flush_e || (s.pcsrc && !s.stall_d)) && m_flush_cnt < CNT_MAX) m_flush_cnt++;
  endtask

  function automatic exp_t model_expect();
    exp_t e;
    e.pcf        = m_pc;
    e.instr_d    = m_d_instr;
    e.pc_plus4_d = m_d_pc4;
    e.rs_e       = m_ops[0].instr[25:21];
    e.rt_e       = m_ops[0].instr[20:16];
    e.rd_e       = m_ops[0].rd;
    e.rw_e       = m_ops[0].rw;
    e.m2r_e      = m_ops[0].m2r;
    e.mw_e       = m_ops[0].mw;
    e.alusrc_e   = m_ops[0].alusrc;
    e.aluc_e     = m_ops[0].aluc;
    e.wr_e       = dest(m_ops[0]);
    e.rw_m       = m_ops[1].rw;
    e.m2r_m      = m_ops[1].m2r;
    e.mw_m       = m_ops[1].mw;
    e.wr_m       = dest(m_ops[1]);
    e.rw_w       = m_ops[2].rw;
    e.m2r_w      = m_ops[2].m2r;
    e.wr_w       = dest(m_ops[2]);
    e.stall_cnt  = 32'(m_stall_cnt);
    e.flush_cnt  = 32'(m_flush_cnt);
    return e;
  endfunction

  task automatic compare(input exp_t e, input string tag);
    check({tag, ".PCF"},         bus.PCF,                e.pcf);
    check({tag, ".InstrD"},      bus.InstrD,             e.instr_d);
    check({tag, ".PCPlus4D"},    bus.PCPlus4D,           e.pc_plus4_d);
    check({tag, ".rsE"},         32'(bus.rsE),           32'(e.rs_e));
    check({tag, ".rtE"},         32'(bus.rtE),           32'(e.rt_e));
    check({tag, ".rdE"},         32'(bus.rdE),           32'(e.rd_e));
    check({tag, ".ctrlE"},       32'({bus.RegWriteE, bus.MemtoRegE, bus.MemWriteE, bus.ALUSrcE}),
                                 32'({e.rw_e, e.m2r_e, e.mw_e, e.alusrc_e}));
    check({tag, ".ALUControlE"}, 32'(bus.ALUControlE),   32'(e.aluc_e));
    check({tag, ".WriteRegE"},   32'(bus.WriteRegE),     32'(e.wr_e));
    check({tag, ".ctrlM"},       32'({bus.RegWriteM, bus.MemtoRegM, bus.MemWriteM}),
                                 32'({e.rw_m, e.m2r_m, e.mw_m}));
    check({tag, ".WriteRegM"},   32'(bus.WriteRegM),     32'(e.wr_m));
    check({tag, ".ctrlW"},       32'({bus.RegWriteW, bus.MemtoRegW}), 32'({e.rw_w, e.m2r_w}));
    check({tag, ".WriteRegW"},   32'(bus.WriteRegW),     32'(e.wr_w));
`ifdef PIPE_PERF_CNT_EN
    check({tag, ".StallCnt"},    32'(bus.StallCnt),      e.stall_cnt);
    check({tag, ".FlushCnt"},    32'(bus.FlushCnt),      e.flush_cnt);
`endif
  endtask

  task automatic drive(input stim_t s);
    bus.StallF      = s.stall_f;
    bus.StallD      = s.stall_d;
    bus.FlushE      = s.flush_e;
    bus.PCSrcD      = s.pcsrc;
    bus.PCBranchD   = s.branch;
    bus.InstrF      = s.instr_f;
    bus.rdD         = s.rd;
    bus.RegWriteD   = s.rw;
    bus.MemtoRegD   = s.m2r;
    bus.MemWriteD   = s.mw;
    bus.RegDstD     = s.regdst;
    bus.ALUSrcD     = s.alusrc;
    bus.ALUControlD = s.aluc;
  endtask

  // Called at a falling edge; returns at the next falling edge after the rising edge was checked.
  task automatic step(input stim_t s);
    drive(s);
    model_edge(s);
    exp_q.push_back(model_expect());
    @(negedge clk);
  endtask

  function automatic stim_t idle(input logic [31:0] instr);
    stim_t s;
    s         = '0;
    s.instr_f = instr;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.stall_d = ($urandom_range(3) == 0);
    s.stall_f = ($urandom_range(9) == 0) ? ~s.stall_d : s.stall_d;
    s.flush_e = s.stall_d ? ($urandom_range(1) == 1) : ($urandom_range(9) == 0);
    s.pcsrc   = ($urandom_range(4) == 0);
    s.branch  = $urandom();
    s.instr_f = $urandom();
    s.rd      = 5'($urandom());
    s.rw      = 1'($urandom());
    s.m2r     = 1'($urandom());
    s.mw      = 1'($urandom());
    s.regdst  = 1'($urandom());
    s.alusrc  = 1'($urandom());
    s.aluc    = 3'($urandom());
    return s;
  endfunction

  // Monitor: one expectation per rising edge while the scoreboard holds any.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare(e, "sb");
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim_t       s;
    logic [31:0] held_pc;
    logic [31:0] held_instr;

    reset = 1'b1;
    drive(idle(32'h0));
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare(model_expect(), "por");
    check("por.PCF_const", bus.PCF, RESET_PC);

    // Free run: PCF steps by 4, InstrD trails InstrF by one edge.
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(idle(32'h2000_0000 + 32'(i)));
      check("run.PCF", bus.PCF, RESET_PC + 32'(4 * (i + 1)));
      check("run.InstrD", bus.InstrD, 32'h2000_0000 + 32'(i));
    end

    // add with rd=3: destination visible in E, M, W on successive edges.
    s = idle(32'h0000_1111);
    s.rd = 5'd3; s.regdst = 1'b1; s.rw = 1'b1;
    step(s);
    check("add.WriteRegE", 32'(bus.WriteRegE), 32'd3);
    step(idle(32'h0000_2222));
    check("add.WriteRegM", 32'(bus.WriteRegM), 32'd3);
    step(idle(32'h0000_3333));
    check("add.WriteRegW", 32'(bus.WriteRegW), 32'd3);
    check("add.RegWriteW", 32'(bus.RegWriteW), 32'd1);

    // Load-use: F and D hold, E bubbles, then the held instruction issues.
    step(idle(32'h0123_4567));
    held_pc    = m_pc;
    held_instr = m_d_instr;
    s = idle(32'hdead_beef);
    s.stall_f = 1'b1; s.stall_d = 1'b1; s.flush_e = 1'b1; s.rw = 1'b1; s.rd = 5'd9;
    step(s);
    check("lu.PCF", bus.PCF, held_pc);
    check("lu.InstrD", bus.InstrD, held_instr);
    check("lu.RegWriteE", 32'(bus.RegWriteE), 32'd0);
    check("lu.WriteRegE", 32'(bus.WriteRegE), 32'd0);
    s = idle(32'h0000_0000);
    s.rw = 1'b1;
    step(s);
    check("lu.reissue_rsE", 32'(bus.rsE), 32'(held_instr[25:21]));
    check("lu.reissue_rtE", 32'(bus.rtE), 32'(held_instr[20:16]));

    // Taken branch flushes D; the same request under stall is ignored.
    s = idle(32'hffff_ffff);
    s.pcsrc = 1'b1; s.branch = 32'h0040_0100;
    step(s);
    check("br.PCF", bus.PCF, 32'h0040_0100);
    check("br.InstrD", bus.InstrD, 32'h0);
    step(idle(32'h0aaa_5555));
    s = idle(32'h0bbb_6666);
    s.pcsrc = 1'b1; s.branch = 32'h0040_0200; s.stall_f = 1'b1; s.stall_d = 1'b1;
    step(s);
    check("brstall.PCF", bus.PCF, 32'h0040_0104);
    check("brstall.InstrD", bus.InstrD, 32'h0aaa_5555);

    // Async reset between edges while stalled.
    s = idle(32'h0ccc_7777);
    s.stall_f = 1'b1; s.stall_d = 1'b1;
    step(s);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    compare(model_expect(), "async");
    check("async.PCF_const", bus.PCF, RESET_PC);
    @(negedge clk);
    reset = 1'b0;

    // Two load-use stalls and one branch flush from a clean reset.
    s = idle(32'h0ddd_8888);
    s.stall_f = 1'b1; s.stall_d = 1'b1; s.flush_e = 1'b1;
    step(s);
    step(s);
    s = idle(32'h0eee_9999);
    s.pcsrc = 1'b1; s.branch = 32'h0040_0300;
    step(s);
`ifdef PIPE_PERF_CNT_EN
    check("cnt.StallCnt", 32'(bus.StallCnt), 32'd2);
    check("cnt.FlushCnt", 32'(bus.FlushCnt), 32'd3);
`endif

    for (int i = 0; i < N_RAND; i++) step(rand_stim());

    check("sb.drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl_regs.md
Name: pipe_ctrl_regs

Overview:
Pipeline-register and PC bank for the 5-stage MIPS core; the consumer of the hazard unit's StallF/StallD/FlushE and the producer of the E/M/W register-address and control fields that the hazard unit compares. It holds PCF, the IF/ID instruction register and the ID/EX, EX/MEM and MEM/WB control and address registers, and applies stall, flush and branch-redirect rules. Datapath values (ALU results, read data) live in separate registers and are not part of this block.

Parameters:
RESET_PC, 32'h0000_0000, PCF value after reset
CNT_W, 32, width of optional performance counters

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high
StallF  in  1  hold PCF
StallD  in  1  hold IF/ID
FlushE  in  1  insert bubble into ID/EX
PCSrcD  in  1  branch taken in decode
PCBranchD  in  32  branch target
InstrF  in  32  fetched instruction
InstrD  out  32  IF/ID instruction
PCF  out  32  fetch PC
PCPlus4D  out  32  IF/ID PC+4
rdD  in  5  decode rd field
RegWriteD, MemtoRegD, MemWriteD, RegDstD, ALUSrcD  in  1 each  decode controls
ALUControlD  in  3  decode ALU op
rsE, rtE, rdE  out  5 each  ID/EX register fields, rs/rt taken from InstrD[25:21]/[20:16]
RegWriteE, MemtoRegE, MemWriteE, ALUSrcE  out  1 each
ALUControlE  out  3
WriteRegE  out  5  RegDstE ? rdE : rtE (combinational)
RegWriteM, MemtoRegM, MemWriteM  out  1 each
WriteRegM  out  5
RegWriteW, MemtoRegW  out  1 each
WriteRegW  out  5
StallCnt, FlushCnt  out  CNT_W each  only when the optional feature is compiled in

Behaviour:
- Reset (async, any time, including mid-stall): PCF=RESET_PC; InstrD=0 (nop); PCPlus4D=0; all E/M/W fields and controls=0; counters=0. Outputs take these values immediately, not at the next edge.
- PC: PCPlus4F=PCF+4 (mod 2^32, wraps). Each edge with StallF=0: PCF <= PCSrcD ? PCBranchD : PCPlus4F. With StallF=1, PCF holds.
- IF/ID: FlushD = PCSrcD & ~StallD.
  - StallD=1: hold InstrD and PCPlus4D. Stall wins over branch flush.
  - Else if FlushD: InstrD<=0 and PCPlus4D<=0.
  - Else: load InstrF and PCF+4.
- ID/EX: FlushE=1 clears all E fields and controls to 0, giving a bubble with RegWriteE=0 and WriteRegE=0. Otherwise load every edge. ID/EX is never stalled.
- EX/MEM and MEM/WB: load every edge, no stall or flush. Latency is one cycle per stage, so a D-stage control reaches W 3 edges later.
- Simultaneous FlushE and StallD, as in a load-use stall: D holds and E bubbles, so the held instruction re-issues on the next non-stalled edge.
- Registers with address 0 pass through unchanged; the hazard unit filters register 0.

Optional Feature:
PIPE_PERF_CNT_EN. When defined: StallCnt increments on each edge with StallD=1, and FlushCnt increments on each edge with FlushE=1 or FlushD=1. Both saturate at all-ones and reset to 0. When undefined: the counter ports and logic are absent, and the other behaviour is identical.

Test Plan:
- Reset with RESET_PC=32'h0040_0000, release, free-run 3 cycles, no stall -> PCF 0x00400000, 0x00400004, 0x00400008, 0x0040000C; InstrD follows InstrF with a 1-edge delay.
- Decode `add` with rd=3, RegDstD=1, RegWriteD=1 -> WriteRegE=3 at edge+1, WriteRegM=3 at edge+2, WriteRegW=3 with RegWriteW=1 at edge+3.
- Load-use: StallF=StallD=FlushE=1 for one cycle -> PCF and InstrD unchanged, RegWriteE=0 and WriteRegE=0; the next cycle re-issues the held InstrD into E.
- PCSrcD=1 with PCBranchD=0x00400100 and StallD=0 -> PCF=0x00400100 and InstrD=0 after the edge. Same with StallD=StallF=1 -> no redirect and no flush; InstrD and PCF held.
- Assert reset mid-stall between edges -> all outputs return to reset values immediately (async), and PCF=RESET_PC.
- With PIPE_PERF_CNT_EN: 2 stall cycles plus 1 branch flush -> StallCnt=2 and FlushCnt=3, because FlushE is also asserted during both stalls.
